k285_multilane_sync: RTL and testbench

//  Parametrised multi-lane K28.5 comma detector and symbol-lock FSM for the RX path.

---
 rtl/k285_pkg.sv | 18 +
 rtl/k285_lane_sync.sv | 164 ++++++++++++++++
 rtl/k285_multilane_sync.sv | 64 ++++++
 tb/tb_k285_multilane_sync.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/k285_pkg.sv
// Shared definitions for the K28.5 multi-lane symbol-lock block.
// Optional feature macro: LANE_ERR_CNT_EN (per-lane lock-loss counters).
package k285_pkg;

  localparam logic [7:0] COMMA_K285 = 8'hBC;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lane_state_e;

  // Saturating 8-bit increment; the error counter sticks at 8'hFF.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/k285_lane_sync.sv
// One RX lane: registered data, comma flag, and the comma-lock FSM.
// Optional feature macro: LANE_ERR_CNT_EN adds a saturating LOCKED->HUNT counter.
//
//  state  | meaning
//  HUNT   | searching for the first comma
//  VERIFY | counting commas, each within MAX_GAP symbols of the last
//  LOCKED | symbol lock; counting consecutive missed comma windows
import k285_pkg::*;

module k285_lane_sync #(
  parameter int            DW         = 8,
  parameter logic [DW-1:0] COMMA      = DW'(COMMA_K285),
  parameter int            LOCK_CNT   = 4,
  parameter int            MAX_GAP    = 16,
  parameter int            UNLOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic [DW-1:0] rx_data_i,
  output logic [DW-1:0] rx_data_o,
  output logic          k285_o,
  output logic          rx_valid_o,
  output logic          lane_locked_o,
  output logic          lock_next_o
`ifdef LANE_ERR_CNT_EN
  , output logic [7:0]  err_cnt_o
`endif
);

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int GW = $clog2(MAX_GAP + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);

  lane_state_e   state_q, state_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d, comma_inc;
  logic [GW-1:0] gap_q, gap_d, gap_inc;
  logic [MW-1:0] miss_q, miss_d, miss_inc;
  logic [DW-1:0] data_q, data_d;
  logic          k285_q, k285_d;
  logic          locked_q, locked_d;
  logic          valid_q, valid_d;
  logic          is_comma;
`ifdef LANE_ERR_CNT_EN
  logic [7:0]    err_q, err_d;
`endif

  assign is_comma  = (rx_data_i == COMMA);
  assign comma_inc = comma_cnt_q + CW'(1);
  assign gap_inc   = gap_q + GW'(1);
  assign miss_inc  = miss_q + MW'(1);

  // Next-state: lock FSM plus output flags, all judged on the incoming symbol.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    gap_d       = gap_q;
    miss_d      = miss_q;
    data_d      = data_q;
    k285_d      = k285_q;
    locked_d    = locked_q;
    valid_d     = valid_q;
`ifdef LANE_ERR_CNT_EN
    err_d       = err_q;
`endif
    if (enb) begin
      case (state_q)
        HUNT: begin
          if (is_comma) begin
            state_d     = VERIFY;
            comma_cnt_d = CW'(1);
            gap_d       = '0;
          end
        end
        VERIFY: begin
          if (is_comma) begin
            comma_cnt_d = comma_inc;
            gap_d       = '0;
            if (comma_inc == CW'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (gap_inc == GW'(MAX_GAP)) begin
            state_d     = HUNT;
            comma_cnt_d = '0;
            gap_d       = '0;
            miss_d      = '0;
          end else begin
            gap_d = gap_inc;
          end
        end
        LOCKED: begin
          if (is_comma) begin
            gap_d  = '0;
            miss_d = '0;
          end else if (gap_inc == GW'(MAX_GAP)) begin
            gap_d = '0;
            if (miss_inc == MW'(UNLOCK_CNT)) begin
              state_d     = HUNT;
              comma_cnt_d = '0;
              miss_d      = '0;
`ifdef LANE_ERR_CNT_EN
              err_d       = sat_inc8(err_q);
`endif
            end else begin
              miss_d = miss_inc;
            end
          end else begin
            gap_d = gap_inc;
          end
        end
        default: begin
          state_d     = HUNT;
          comma_cnt_d = '0;
          gap_d       = '0;
          miss_d      = '0;
        end
      endcase
      data_d   = rx_data_i;
      k285_d   = is_comma;
      locked_d = (state_d == LOCKED);
      valid_d  = locked_d && !is_comma;
    end
  end

  // State and output registers; reset wins over the symbol strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      comma_cnt_q <= '0;
      gap_q       <= '0;
      miss_q      <= '0;
      data_q      <= '0;
      k285_q      <= 1'b0;
      locked_q    <= 1'b0;
      valid_q     <= 1'b0;
`ifdef LANE_ERR_CNT_EN
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      gap_q       <= gap_d;
      miss_q      <= miss_d;
      data_q      <= data_d;
      k285_q      <= k285_d;
      locked_q    <= locked_d;
      valid_q     <= valid_d;
`ifdef LANE_ERR_CNT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign rx_data_o     = data_q;
  assign k285_o        = k285_q;
  assign rx_valid_o    = valid_q;
  assign lane_locked_o = locked_q;
  assign lock_next_o   = locked_d;
`ifdef LANE_ERR_CNT_EN
  assign err_cnt_o     = err_q;
`endif

endmodule

// File: rtl/k285_multilane_sync.sv
// Multi-lane K28.5 comma detector / symbol-lock wrapper for the RX path.
// Optional feature macro: LANE_ERR_CNT_EN exposes per-lane lock-loss counters.
import k285_pkg::*;

module k285_multilane_sync #(
  parameter int            NLANES     = 4,
  parameter int            DW         = 8,
  parameter logic [DW-1:0] COMMA      = DW'(COMMA_K285),
  parameter int            LOCK_CNT   = 4,
  parameter int            MAX_GAP    = 16,
  parameter int            UNLOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic [NLANES*DW-1:0] rx_data_i,
  output logic [NLANES*DW-1:0] rx_data_o,
  output logic [NLANES-1:0]    k285_o,
  output logic [NLANES-1:0]    rx_valid_o,
  output logic [NLANES-1:0]    lane_locked_o,
  output logic                 all_locked_o
`ifdef LANE_ERR_CNT_EN
  , output logic [NLANES*8-1:0] err_cnt_o
`endif
);

  logic [NLANES-1:0] lock_next;
  logic              all_locked_q;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    k285_lane_sync #(
      .DW         (DW),
      .COMMA      (COMMA),
      .LOCK_CNT   (LOCK_CNT),
      .MAX_GAP    (MAX_GAP),
      .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .enb           (enb),
      .rx_data_i     (rx_data_i[i*DW +: DW]),
      .rx_data_o     (rx_data_o[i*DW +: DW]),
      .k285_o        (k285_o[i]),
      .rx_valid_o    (rx_valid_o[i]),
      .lane_locked_o (lane_locked_o[i]),
      .lock_next_o   (lock_next[i])
`ifdef LANE_ERR_CNT_EN
      , .err_cnt_o   (err_cnt_o[i*8 +: 8])
`endif
    );
  end

  // Aggregate lock from next-state lane locks so it moves with lane_locked_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      all_locked_q <= 1'b0;
    end else if (enb) begin
      all_locked_q <= &lock_next;
    end
  end

  assign all_locked_o = all_locked_q;

endmodule

// File: tb/tb_k285_multilane_sync.sv
// Directed bench for k285_multilane_sync (4 lanes, LOCK_CNT=4, MAX_GAP=16, UNLOCK_CNT=4).
// Define LANE_ERR_CNT_EN to also exercise the lock-loss counters.
module tb_k285_multilane_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [31:0] rx_data_i;
  logic [31:0] rx_data_o;
  logic [3:0]  k285_o;
  logic [3:0]  rx_valid_o;
  logic [3:0]  lane_locked_o;
  logic        all_locked_o;
`ifdef LANE_ERR_CNT_EN
  logic [31:0] err_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  k285_multilane_sync #(
    .NLANES(4), .DW(8), .COMMA(8'hBC), .LOCK_CNT(4), .MAX_GAP(16), .UNLOCK_CNT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enb           (enb),
    .rx_data_i     (rx_data_i),
    .rx_data_o     (rx_data_o),
    .k285_o        (k285_o),
    .rx_valid_o    (rx_valid_o),
    .lane_locked_o (lane_locked_o),
    .all_locked_o  (all_locked_o)
`ifdef LANE_ERR_CNT_EN
    , .err_cnt_o   (err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic [31:0] d);
    rx_data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) step(d);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] dat, input logic [3:0] k,
                          input logic [3:0] v, input logic [3:0] l, input logic a);
    chk({tag, ".rx_data"}, rx_data_o, dat);
    chk({tag, ".k285"}, {28'd0, k285_o}, {28'd0, k});
    chk({tag, ".valid"}, {28'd0, rx_valid_o}, {28'd0, v});
    chk({tag, ".locked"}, {28'd0, lane_locked_o}, {28'd0, l});
    chk({tag, ".all_locked"}, {31'd0, all_locked_o}, {31'd0, a});
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    enb = 1'b1;
    rx_data_i = '0;

    // 1. Reset with random data, then idle zeros
    for (int k = 0; k < 3; k++) step($urandom);
    chk_outs("reset", 32'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    steps(32'h0, 3);
    chk_outs("idle", 32'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // 2. Lane0 comma every 8 symbols
    for (int c = 0; c < 3; c++) begin
      step(32'h0000_00BC);
      steps(32'h0, 7);
    end
    chk("lock.pre3", {28'd0, lane_locked_o}, 32'h0);
    step(32'h0000_00BC);
    chk_outs("lock.4th", 32'h0000_00BC, 4'h1, 4'h0, 4'h1, 1'b0);
    step(32'h0);
    chk_outs("lock.payload", 32'h0, 4'h0, 4'h1, 4'h1, 1'b0);

    // 4. Lock loss on lane0, with one comma at symbol 50 resetting the miss count
    steps(32'h0, 48);
    chk_outs("loss.sym49", 32'h0, 4'h0, 4'h1, 4'h1, 1'b0);
    step(32'h0000_00BC);
    chk_outs("loss.sym50bc", 32'h0000_00BC, 4'h1, 4'h0, 4'h1, 1'b0);
    steps(32'h0, 63);
    chk_outs("loss.held63", 32'h0, 4'h0, 4'h1, 4'h1, 1'b0);
    step(32'h0);
    chk_outs("loss.drop64", 32'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // 3. Verify timeout on lane1; count restarts from 1 afterwards
    steps(32'h0000_BC00, 2);
    steps(32'h0, 16);
    steps(32'h0000_BC00, 3);
    chk("timeout.3bc", {31'd0, lane_locked_o[1]}, 32'd0);
    step(32'h0000_BC00);
    chk("timeout.4bc", {31'd0, lane_locked_o[1]}, 32'd1);
    // Boundary: 15 non-commas between commas keeps VERIFY alive on lane2
    for (int c = 0; c < 3; c++) begin
      step(32'h00BC_0000);
      steps(32'h0, 15);
    end
    chk("gap15.pre", {31'd0, lane_locked_o[2]}, 32'd0);
    step(32'h00BC_0000);
    chk("gap15.lock", {30'd0, k285_o[2], lane_locked_o[2]}, 32'd3);

    // 6. Staggered lock: lane i gets commas at steps i, i+4, i+8, i+12
    rst = 1'b1;
    step(32'h0);
    rst = 1'b0;
    for (int s = 0; s < 15; s++) begin
      d = '0;
      for (int i = 0; i < 4; i++)
        if (s >= i && ((s - i) % 4) == 0) d[i*8 +: 8] = 8'hBC;
      step(d);
    end
    chk_outs("stagger.s14", 32'h00BC_0000, 4'h4, 4'h3, 4'h7, 1'b0);
    step(32'hBC00_0000);
    chk_outs("stagger.s15", 32'hBC00_0000, 4'h8, 4'h7, 4'hF, 1'b1);

    // 5. enb gating: outputs frozen, gap counters do not advance
    enb = 1'b0;
    steps(32'h5555_5555, 100);
    chk_outs("enb.frozen", 32'hBC00_0000, 4'h8, 4'h7, 4'hF, 1'b1);
    enb = 1'b1;
    steps(32'h0, 60);
    chk_outs("enb.gap60", 32'h0, 4'h0, 4'hF, 4'hF, 1'b1);
    step(32'h0);
    chk_outs("enb.gap61", 32'h0, 4'h0, 4'hE, 4'hE, 1'b0);
    step(32'h0);
    chk("enb.gap62", {28'd0, lane_locked_o}, 32'hC);

    // Relock all lanes, then reset with enb low drops everything next edge
    steps(32'hBCBC_BCBC, 4);
    chk_outs("relock", 32'hBCBC_BCBC, 4'hF, 4'h0, 4'hF, 1'b1);
    rst = 1'b1;
    enb = 1'b0;
    step(32'hBCBC_BCBC);
    chk_outs("rst.midlock", 32'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    enb = 1'b1;

`ifdef LANE_ERR_CNT_EN
    chk("err.reset", err_cnt_o, 32'h0);
    for (int e = 0; e < 300; e++) begin
      steps(32'hBCBC_BCBC, 4);
      steps(32'h0, 64);
      if (e == 0) chk("err.one", err_cnt_o, 32'h0101_0101);
    end
    chk("err.sat", err_cnt_o, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
